supervisor_retorno_piso1: RTL and testbench
===========================================

# supervisor_retorno_piso1

Idle-return supervisor for the freight-elevator controller. It sits downstream of the 1-minute idle counter: it drives the counter's `iniciaCuenta` enable and watches its `cuenta` output. When the car has sat idle away from the base floor for one full minute, it raises a return-to-floor-1 request toward the main floor controller. It also tracks the return trip until completion.

## Interface
- `DIVISOR`, 14'd9000: counter period; terminal count is `DIVISOR-1` (60 s at 150 Hz).
- `PISO_BASE`, 2'd0: encoded base floor (floor 1).
- `clockInt_150Hz`  in  1: system clock, 150 Hz. This is the only clock.
- `resetN`  in  1: reset, synchronous and active-low.
- `pisoActual`  in  2: current floor, encoded 0..3.
- `enMovimiento`  in  1: car is moving.
- `puertaAbierta`  in  1: door is open.
- `solicitudes`  in  4: pending floor calls, one-hot per floor.
- `cuenta`  in  14: count from the idle counter.
- `ackPedido`  in  1: main controller accepts the return request (1-cycle pulse).
- `iniciaCuenta`  out  1: enable/clear for the idle counter.
- `pedidoPiso1`  out  1: return-to-base request.
- `retornoActivo`  out  1: return trip in progress.
- `retornos`  out  8: saturating count of completed returns.

## Operation
- `ocioso` = `!enMovimiento && !puertaAbierta && solicitudes==4'b0 && pisoActual!=PISO_BASE` (combinational).
- Four-state Moore FSM:
  - INACTIVO: all outputs 0 except `retornos`. Goes to CONTANDO if `ocioso`.
  - CONTANDO: `iniciaCuenta`=1.
    - Goes to INACTIVO if `!ocioso`.
    - Otherwise goes to PIDIENDO if `cuenta==DIVISOR-1`.
  - PIDIENDO: `pedidoPiso1`=1 and `iniciaCuenta`=0.
    - Goes to VIAJANDO on `ackPedido`.
    - Otherwise goes to INACTIVO if `solicitudes!=0` (a user call cancels the request).
  - VIAJANDO: `retornoActivo`=1.
    - Goes to INACTIVO and increments `retornos` (saturates at 255) when `pisoActual==PISO_BASE && !enMovimiento`.
    - Otherwise goes to INACTIVO without incrementing if `solicitudes!=0`.
- `pedidoPiso1` is level-held until ack or cancel. `ackPedido` outside PIDIENDO is ignored.
- All inputs are synchronous to `clockInt_150Hz`; this block does no synchronization.

## Timing
- Reset (`resetN`=0 at an edge): state=INACTIVO, `iniciaCuenta`=0, `pedidoPiso1`=0, `retornoActivo`=0, `retornos`=0. The counter clears on the next edge because `iniciaCuenta`=0.
- Reset mid-operation (any state) follows the same rule. A pending request is dropped without ack.
- Outputs are decoded from the state register only, so they have no combinational path from inputs.
- Latency:
  - `ocioso` sampled at edge k puts the FSM in CONTANDO after edge k.
  - The counter holds 0 through cycle k+1 and reaches 8999 after edge k+8999.
  - The FSM enters PIDIENDO at edge k+9000, so `pedidoPiso1` rises 9000 cycles (60 s) after `iniciaCuenta` rises.
- The counter wraps to 0 on the same edge that the FSM leaves CONTANDO. `iniciaCuenta`=0 then holds the counter at 0.
- Simultaneous events:
  - CONTANDO, terminal count and `!ocioso` on the same edge: go to INACTIVO (loss of idle wins).
  - PIDIENDO, `ackPedido` and `solicitudes!=0` on the same edge: go to VIAJANDO (ack wins).
  - VIAJANDO, arrival and `solicitudes!=0` on the same edge: arrival wins and `retornos` increments.
- Car already at `PISO_BASE`: `ocioso`=0, so the FSM never counts.

## Structure
- Shared package `montacargas_pkg`: state encoding constants (INACTIVO=2'd0, CONTANDO=2'd1, PIDIENDO=2'd2, VIAJANDO=2'd3), `PISO_BASE`, and floor encoding.
- The idle counter is instantiated beside this block at the montacargas top level, not inside it.
- One sub-module: `contador_saturado` (8-bit, enable, synchronous active-low clear) for `retornos`.
- Budget: roughly 150–200 lines of RTL.

## Test plan
1. Idle-to-request: `pisoActual`=2, no calls, door closed, stopped → `iniciaCuenta` high next cycle; `pedidoPiso1` high exactly 9000 cycles later.
2. Interrupted idle: same setup, then `solicitudes`=4'b0001 at cycle 5000 → INACTIVO next edge, `iniciaCuenta`=0, counter back to 0, no request.
3. Full return: from test 1, `ackPedido` pulse → `retornoActivo`=1; drive `pisoActual`=0 with `enMovimiento`=0 → INACTIVO and `retornos`=1.
4. Simultaneous ack and call in PIDIENDO → VIAJANDO. Separately, a call alone in PIDIENDO → INACTIVO with `pedidoPiso1` dropped next cycle.
5. Reset mid-operation: `resetN`=0 at cycle 4000 of CONTANDO and again in VIAJANDO → all outputs 0 after that edge and `retornos`=0.
6. Saturation: force 260 complete return cycles → `retornos`=255. Separately, `pisoActual`=0 and idle → no counting.

Source files
------------

// File: rtl/montacargas_pkg.sv
// Shared definitions for the freight-elevator (montacargas) controller:
// supervisor state encoding, floor encoding and the idle-counter period.
package montacargas_pkg;

    // Idle-return supervisor states
    typedef enum logic [1:0] {
        INACTIVO = 2'd0,   // car busy, at base, or not yet idle
        CONTANDO = 2'd1,   // idle away from base, idle counter running
        PIDIENDO = 2'd2,   // return-to-floor-1 request held toward main controller
        VIAJANDO = 2'd3    // return trip accepted and in progress
    } estado_t;

    // Floor encoding (floor N is encoded as N-1)
    localparam logic [1:0] PISO_1 = 2'd0;
    localparam logic [1:0] PISO_2 = 2'd1;
    localparam logic [1:0] PISO_3 = 2'd2;
    localparam logic [1:0] PISO_4 = 2'd3;

    // Base floor the car returns to when left idle
    localparam logic [1:0] PISO_BASE = PISO_1;

    // Idle counter period: 60 s at 150 Hz
    localparam logic [13:0] DIVISOR_DEF = 14'd9000;

    // Car is idle away from the base floor: stopped, door shut, no calls pending
    function automatic logic es_ocioso(
        input logic       en_mov,
        input logic       puerta,
        input logic [3:0] sol,
        input logic [1:0] piso,
        input logic [1:0] base
    );
        return !en_mov && !puerta && (sol == 4'b0000) && (piso != base);
    endfunction

endpackage

// File: rtl/supervisor_retorno_piso1_contador_saturado.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Used to tally completed returns to the base floor.
module contador_saturado #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_cuenta
);

    localparam logic [W-1:0] MAXIMO = '1;

    logic [W-1:0] r_cuenta;

    // Count enabled events, sticking at the maximum instead of wrapping
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_cuenta <= '0;
        end else if (i_en && (r_cuenta != MAXIMO)) begin
            r_cuenta <= r_cuenta + W'(1);
        end
    end

    assign o_cuenta = r_cuenta;

endmodule

// File: rtl/supervisor_retorno_piso1.sv
// Idle-return supervisor. Enables the external 1-minute idle counter while the
// car sits idle away from floor 1, raises a return request on terminal count,
// and follows the return trip until the car is stopped at floor 1.
//
// Handshake with the main controller: pedidoPiso1 is a level held high for as
// long as the FSM is in PIDIENDO; ackPedido is a one-cycle pulse that is only
// honoured while pedidoPiso1 is high and is ignored in every other state. A
// pending call (solicitudes != 0) withdraws the request unless ack arrives on
// the same edge, in which case ack wins.
module supervisor_retorno_piso1 #(
    parameter logic [13:0] DIVISOR   = montacargas_pkg::DIVISOR_DEF,
    parameter logic [1:0]  PISO_BASE = montacargas_pkg::PISO_BASE
) (
    input  logic                     clockInt_150Hz,
    input  logic                     resetN,
    input  logic [1:0]               pisoActual,
    input  logic                     enMovimiento,
    input  logic                     puertaAbierta,
    input  logic [3:0]               solicitudes,
    input  logic [13:0]              cuenta,
    input  logic                     ackPedido,
    output logic                     iniciaCuenta,
    output logic                     pedidoPiso1,
    output logic                     retornoActivo,
    output logic [7:0]               retornos,
    output montacargas_pkg::estado_t estadoDbg
);

    import montacargas_pkg::*;

    localparam logic [13:0] TERMINAL = DIVISOR - 14'd1;

    estado_t r_estado;
    estado_t w_estado_sig;
    logic    r_inicia_cuenta;
    logic    r_pedido;
    logic    r_retorno_activo;

    logic    w_ocioso;
    logic    w_hay_llamada;
    logic    w_llegada;
    logic    w_fin_cuenta;
    logic    w_incrementa;

    assign w_ocioso      = es_ocioso(enMovimiento, puertaAbierta, solicitudes,
                                     pisoActual, PISO_BASE);
    assign w_hay_llamada = (solicitudes != 4'b0000);
    assign w_llegada     = (pisoActual == PISO_BASE) && !enMovimiento;
    assign w_fin_cuenta  = (cuenta == TERMINAL);

    // Next-state decision; priorities: loss of idle over terminal count,
    // ack over cancel, arrival over cancel
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            INACTIVO: begin
                if (w_ocioso) w_estado_sig = CONTANDO;
            end
            CONTANDO: begin
                if (!w_ocioso)         w_estado_sig = INACTIVO;
                else if (w_fin_cuenta) w_estado_sig = PIDIENDO;
            end
            PIDIENDO: begin
                if (ackPedido)          w_estado_sig = VIAJANDO;
                else if (w_hay_llamada) w_estado_sig = INACTIVO;
            end
            VIAJANDO: begin
                if (w_llegada)          w_estado_sig = INACTIVO;
                else if (w_hay_llamada) w_estado_sig = INACTIVO;
            end
            default: w_estado_sig = INACTIVO;
        endcase
    end

    // State register with Moore outputs registered from the state being entered
    always_ff @(posedge clockInt_150Hz) begin
        if (!resetN) begin
            r_estado         <= INACTIVO;
            r_inicia_cuenta  <= 1'b0;
            r_pedido         <= 1'b0;
            r_retorno_activo <= 1'b0;
        end else begin
            r_estado         <= w_estado_sig;
            r_inicia_cuenta  <= (w_estado_sig == CONTANDO);
            r_pedido         <= (w_estado_sig == PIDIENDO);
            r_retorno_activo <= (w_estado_sig == VIAJANDO);
        end
    end

    // A return completes on the edge the car is seen stopped at the base floor
    assign w_incrementa = (r_estado == VIAJANDO) && w_llegada;

    contador_saturado #(
        .W (8)
    ) u_retornos (
        .i_clk    (clockInt_150Hz),
        .i_clr_n  (resetN),
        .i_en     (w_incrementa),
        .o_cuenta (retornos)
    );

    assign iniciaCuenta  = r_inicia_cuenta;
    assign pedidoPiso1   = r_pedido;
    assign retornoActivo = r_retorno_activo;
    assign estadoDbg     = r_estado;

endmodule

// File: tb/tb_supervisor_retorno_piso1.sv
// Directed bench for the idle-return supervisor. A small model of the external
// idle counter drives cuenta; it can be overridden with a fixed value to reach
// the terminal count quickly.
module tb_supervisor_retorno_piso1;

    import montacargas_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic [1:0]  piso;
    logic        en_mov;
    logic        puerta;
    logic [3:0]  sol;
    logic        ack;
    logic [13:0] cuenta;

    logic        inicia_cuenta;
    logic        pedido;
    logic        retorno_activo;
    logic [7:0]  retornos;
    estado_t     estado;

    // Idle counter model: clears while disabled, wraps after 8999
    logic [13:0] cnt_model = 14'd0;
    logic        force_en  = 1'b0;
    logic [13:0] force_val = 14'd0;

    always @(posedge clk) begin
        if (!inicia_cuenta || cnt_model == 14'd8999) cnt_model <= 14'd0;
        else                                          cnt_model <= cnt_model + 14'd1;
    end

    assign cuenta = force_en ? force_val : cnt_model;

    supervisor_retorno_piso1 dut (
        .clockInt_150Hz (clk),
        .resetN         (resetN),
        .pisoActual     (piso),
        .enMovimiento   (en_mov),
        .puertaAbierta  (puerta),
        .solicitudes    (sol),
        .cuenta         (cuenta),
        .ackPedido      (ack),
        .iniciaCuenta   (inicia_cuenta),
        .pedidoPiso1    (pedido),
        .retornoActivo  (retorno_activo),
        .retornos       (retornos),
        .estadoDbg      (estado)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one complete return using the forced terminal count
    task automatic quick_return();
        piso      = PISO_2;
        sol       = 4'b0000;
        en_mov    = 1'b0;
        puerta    = 1'b0;
        force_en  = 1'b1;
        force_val = 14'd8999;
        step();                 // -> CONTANDO
        step();                 // -> PIDIENDO
        ack = 1'b1;
        step();                 // -> VIAJANDO
        ack      = 1'b0;
        force_en = 1'b0;
        piso     = PISO_1;
        step();                 // arrival -> INACTIVO, count
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetN = 1'b0;
        piso   = PISO_3;
        en_mov = 1'b0;
        puerta = 1'b0;
        sol    = 4'b0000;
        ack    = 1'b0;
        step();
        step();
        checks++; if (inicia_cuenta !== 1'b0) begin errors++; $display("FAIL reset_inicia: got %0d expected 0", inicia_cuenta); end
        checks++; if (pedido !== 1'b0) begin errors++; $display("FAIL reset_pedido: got %0d expected 0", pedido); end
        checks++; if (retorno_activo !== 1'b0) begin errors++; $display("FAIL reset_retorno: got %0d expected 0", retorno_activo); end
        checks++; if (retornos !== 8'd0) begin errors++; $display("FAIL reset_retornos: got %0d expected 0", retornos); end
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL reset_estado: got %0d expected 0", estado); end
        sol    = 4'b0001;       // not idle when leaving reset
        resetN = 1'b1;
        step();
    endtask

    task automatic test_idle_request();
        int n;
        sol  = 4'b0000;
        piso = PISO_3;
        step();
        checks++; if (inicia_cuenta !== 1'b1) begin errors++; $display("FAIL idle_inicia: got %0d expected 1", inicia_cuenta); end
        checks++; if (estado !== CONTANDO) begin errors++; $display("FAIL idle_estado: got %0d expected 1", estado); end
        checks++; if (pedido !== 1'b0) begin errors++; $display("FAIL idle_no_pedido: got %0d expected 0", pedido); end
        n = 0;
        while (pedido !== 1'b1 && n < 10000) begin
            step();
            n++;
        end
        checks++; if (n !== 9000) begin errors++; $display("FAIL idle_latency: got %0d cycles expected 9000", n); end
        checks++; if (inicia_cuenta !== 1'b0) begin errors++; $display("FAIL idle_inicia_off: got %0d expected 0", inicia_cuenta); end
        checks++; if (cuenta !== 14'd0) begin errors++; $display("FAIL idle_wrap: got %0d expected 0", cuenta); end
    endtask

    task automatic test_full_return();
        repeat (3) step();
        checks++; if (pedido !== 1'b1) begin errors++; $display("FAIL ret_pedido_held: got %0d expected 1", pedido); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (retorno_activo !== 1'b1) begin errors++; $display("FAIL ret_activo: got %0d expected 1", retorno_activo); end
        checks++; if (pedido !== 1'b0) begin errors++; $display("FAIL ret_pedido_off: got %0d expected 0", pedido); end
        en_mov = 1'b1;
        piso   = PISO_2;
        step();
        piso = PISO_1;
        step();                 // at base but still moving
        checks++; if (estado !== VIAJANDO) begin errors++; $display("FAIL ret_moving: got %0d expected 3", estado); end
        checks++; if (retornos !== 8'd0) begin errors++; $display("FAIL ret_not_yet: got %0d expected 0", retornos); end
        en_mov = 1'b0;
        step();
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL ret_done_estado: got %0d expected 0", estado); end
        checks++; if (retornos !== 8'd1) begin errors++; $display("FAIL ret_count: got %0d expected 1", retornos); end
        checks++; if (retorno_activo !== 1'b0) begin errors++; $display("FAIL ret_activo_off: got %0d expected 0", retorno_activo); end
    endtask

    task automatic test_interrupted();
        sol  = 4'b0000;
        piso = PISO_3;
        step();
        repeat (4999) step();
        checks++; if (cuenta !== 14'd4999) begin errors++; $display("FAIL int_count: got %0d expected 4999", cuenta); end
        sol = 4'b0001;
        step();
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL int_estado: got %0d expected 0", estado); end
        checks++; if (inicia_cuenta !== 1'b0) begin errors++; $display("FAIL int_inicia: got %0d expected 0", inicia_cuenta); end
        step();
        checks++; if (cuenta !== 14'd0) begin errors++; $display("FAIL int_clear: got %0d expected 0", cuenta); end
        repeat (20) step();
        checks++; if (pedido !== 1'b0) begin errors++; $display("FAIL int_no_pedido: got %0d expected 0", pedido); end
    endtask

    task automatic test_simultaneous();
        // terminal count and loss of idle together
        sol  = 4'b0000;
        piso = PISO_4;
        step();
        force_en  = 1'b1;
        force_val = 14'd8999;
        sol       = 4'b0001;
        step();
        force_en = 1'b0;
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL sim_tc_idle: got %0d expected 0", estado); end
        // ack and call together -> VIAJANDO, then arrival with call -> counted
        sol      = 4'b0000;
        force_en = 1'b1;
        step();
        step();
        force_en = 1'b0;
        checks++; if (pedido !== 1'b1) begin errors++; $display("FAIL sim_pedido: got %0d expected 1", pedido); end
        ack = 1'b1;
        sol = 4'b0100;
        step();
        ack = 1'b0;
        checks++; if (estado !== VIAJANDO) begin errors++; $display("FAIL sim_ack_wins: got %0d expected 3", estado); end
        piso = PISO_1;
        step();
        checks++; if (retornos !== 8'd2) begin errors++; $display("FAIL sim_arrival_wins: got %0d expected 2", retornos); end
        // call alone in PIDIENDO cancels
        sol      = 4'b0000;
        piso     = PISO_3;
        force_en = 1'b1;
        step();
        step();
        force_en = 1'b0;
        sol      = 4'b0010;
        step();
        checks++; if (pedido !== 1'b0) begin errors++; $display("FAIL sim_cancel_pedido: got %0d expected 0", pedido); end
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL sim_cancel_estado: got %0d expected 0", estado); end
        // ack outside PIDIENDO is ignored
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (retorno_activo !== 1'b0) begin errors++; $display("FAIL sim_stray_ack: got %0d expected 0", retorno_activo); end
        // call during the trip abandons it without counting
        sol      = 4'b0000;
        force_en = 1'b1;
        step();
        step();
        ack = 1'b1;
        step();
        ack      = 1'b0;
        force_en = 1'b0;
        sol      = 4'b1000;
        step();
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL sim_trip_cancel: got %0d expected 0", estado); end
        checks++; if (retornos !== 8'd2) begin errors++; $display("FAIL sim_trip_nocount: got %0d expected 2", retornos); end
    endtask

    task automatic test_reset_mid();
        sol  = 4'b0000;
        piso = PISO_2;
        step();
        repeat (4000) step();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        checks++; if (inicia_cuenta !== 1'b0) begin errors++; $display("FAIL rmid_inicia: got %0d expected 0", inicia_cuenta); end
        checks++; if (retornos !== 8'd0) begin errors++; $display("FAIL rmid_retornos: got %0d expected 0", retornos); end
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL rmid_estado: got %0d expected 0", estado); end
        quick_return();
        checks++; if (retornos !== 8'd1) begin errors++; $display("FAIL rmid_one: got %0d expected 1", retornos); end
        piso      = PISO_2;
        force_en  = 1'b1;
        force_val = 14'd8999;
        step();
        step();
        ack = 1'b1;
        step();
        ack      = 1'b0;
        force_en = 1'b0;
        checks++; if (retorno_activo !== 1'b1) begin errors++; $display("FAIL rmid_trip: got %0d expected 1", retorno_activo); end
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        checks++; if (retorno_activo !== 1'b0) begin errors++; $display("FAIL rmid_trip_off: got %0d expected 0", retorno_activo); end
        checks++; if (pedido !== 1'b0) begin errors++; $display("FAIL rmid_pedido: got %0d expected 0", pedido); end
        checks++; if (retornos !== 8'd0) begin errors++; $display("FAIL rmid_retornos2: got %0d expected 0", retornos); end
    endtask

    task automatic test_saturation();
        logic saw_count;
        for (int i = 0; i < 254; i++) quick_return();
        checks++; if (retornos !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", retornos); end
        for (int i = 0; i < 6; i++) quick_return();
        checks++; if (retornos !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", retornos); end
        // idle at the base floor never starts counting
        piso      = PISO_1;
        sol       = 4'b0000;
        en_mov    = 1'b0;
        puerta    = 1'b0;
        saw_count = 1'b0;
        repeat (20) begin
            step();
            if (inicia_cuenta !== 1'b0) saw_count = 1'b1;
        end
        checks++; if (saw_count !== 1'b0) begin errors++; $display("FAIL base_no_count: got %0d expected 0", saw_count); end
        checks++; if (estado !== INACTIVO) begin errors++; $display("FAIL base_estado: got %0d expected 0", estado); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_idle_request();
        test_full_return();
        test_interrupted();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Time bound on the whole run
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got no completion expected finish before 2000000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
